// File: rtl/mem_ctrl.sv
// Load/store controller in front of the on-chip byte RAM: range-checks one CPU
// request at a time, issues a single registered RAM cycle and formats load data.
module mem_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int MEM_BYTES   = 2048,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic              I_clk,
  input  logic              I_reset,
  input  logic              I_req,
  input  logic              I_write,
  input  logic [1:0]        I_size,
  input  logic              I_signed,
  input  logic [ADDR_W-1:0] I_addr,
  input  logic [15:0]       I_wdata,
  output logic              O_busy,
  output logic              O_ack,
  output logic              O_fault,
  output logic [15:0]       O_rdata,
  output logic              O_ram_enable,
  output logic              O_ram_write,
  output logic [1:0]        O_ram_size,
  output logic [ADDR_W-1:0] O_ram_addr,
  output logic [15:0]       O_ram_data,
  input  logic [15:0]       I_ram_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] LP_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  state_t r_state;
  state_t w_state_next;

  // request registers, captured at every accept
  logic              r_write;
  logic [1:0]        r_size;
  logic              r_signed;

  logic              r_ack;
  logic              r_fault;
  logic [15:0]       r_rdata;
  logic              r_ram_enable;
  logic              r_ram_write;
  logic [1:0]        r_ram_size;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [15:0]       r_ram_data;

  logic              w_accept;
  logic              w_is_byte;
  logic              w_is_word;
  logic              w_illegal;
  logic [ADDR_W:0]   w_addr_ext;
  logic [ADDR_W:0]   w_addr_last;
  logic [15:0]       w_load_fmt;

  // one extra bit so addr+1 cannot wrap past the limit
  assign w_addr_ext  = {1'b0, I_addr};
  assign w_addr_last = w_addr_ext + (ADDR_W+1)'(1);
  assign w_is_byte   = (I_size == 2'd1);
  assign w_is_word   = (I_size == 2'd2);
  assign w_accept    = (r_state == S_IDLE) && I_req;

  assign w_illegal = !(w_is_byte || w_is_word)
                   || (w_addr_ext >= LP_LIMIT)
                   || (w_is_word && (w_addr_last >= LP_LIMIT))
                   || (ALIGN_CHECK && w_is_word && I_addr[0]);

  assign w_load_fmt = (r_size == 2'd1)
                    ? {(r_signed ? {8{I_ram_data[7]}} : 8'h00), I_ram_data[7:0]}
                    : I_ram_data;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && !w_illegal) w_state_next = S_ISSUE;
      S_ISSUE: w_state_next = r_write ? S_IDLE : S_WAIT;
      S_WAIT:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      r_write      <= 1'b0;
      r_size       <= 2'd0;
      r_signed     <= 1'b0;
      r_ack        <= 1'b0;
      r_fault      <= 1'b0;
      r_rdata      <= 16'h0000;
      r_ram_enable <= 1'b0;
      r_ram_write  <= 1'b0;
      r_ram_size   <= 2'd0;
      r_ram_addr   <= '0;
      r_ram_data   <= 16'h0000;
    end else begin
      r_ack        <= 1'b0;
      r_fault      <= 1'b0;
      r_ram_enable <= 1'b0;
      if (w_accept) begin
        r_write  <= I_write;
        r_size   <= I_size;
        r_signed <= I_signed;
        if (w_illegal) begin
          r_ack   <= 1'b1;
          r_fault <= 1'b1;
          r_rdata <= 16'h0000;
        end else begin
          // RAM-side registers load at accept so the ISSUE cycle sees them
          r_ram_enable <= 1'b1;
          r_ram_write  <= I_write;
          r_ram_size   <= I_size;
          r_ram_addr   <= I_addr;
          r_ram_data   <= w_is_byte ? {8'h00, I_wdata[7:0]} : I_wdata;
        end
      end
      if ((r_state == S_ISSUE) && r_write) r_ack <= 1'b1;
      if (r_state == S_WAIT) begin
        r_ack   <= 1'b1;
        r_rdata <= w_load_fmt;
      end
    end
  end

  assign O_busy       = (r_state != S_IDLE);
  assign O_ack        = r_ack;
  assign O_fault      = r_fault;
  assign O_rdata      = r_rdata;
  assign O_ram_enable = r_ram_enable;
  assign O_ram_write  = r_ram_write;
  assign O_ram_size   = r_ram_size;
  assign O_ram_addr   = r_ram_addr;
  assign O_ram_data   = r_ram_data;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a behavioural byte RAM (registered read).
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        write;
  logic [1:0]  size;
  logic        sgn;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        busy;
  logic        ack;
  logic        fault;
  logic [15:0] rdata;
  logic        ram_enable;
  logic        ram_write;
  logic [1:0]  ram_size;
  logic [15:0] ram_addr;
  logic [15:0] ram_data;
  logic [15:0] ram_q;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(16), .MEM_BYTES(2048), .ALIGN_CHECK(1'b1)) dut (
    .I_clk(clk), .I_reset(reset), .I_req(req), .I_write(write), .I_size(size),
    .I_signed(sgn), .I_addr(addr), .I_wdata(wdata), .O_busy(busy), .O_ack(ack),
    .O_fault(fault), .O_rdata(rdata), .O_ram_enable(ram_enable),
    .O_ram_write(ram_write), .O_ram_size(ram_size), .O_ram_addr(ram_addr),
    .O_ram_data(ram_data), .I_ram_data(ram_q)
  );

  // byte RAM, little-endian, registered read of two bytes
  logic [7:0]  mem [0:2047];
  logic [10:0] ram_idx;
  logic        mem_clr;
  assign ram_idx = ram_addr[10:0];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 2048; i++) mem[i] <= (i == 34) ? 8'h7E : 8'h00;
    end else if (ram_enable) begin
      if (ram_write) begin
        mem[ram_idx] <= ram_data[7:0];
        if (ram_size == 2'd2) mem[ram_idx + 11'd1] <= ram_data[15:8];
      end else begin
        ram_q <= {mem[ram_idx + 11'd1], mem[ram_idx]};
      end
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  // observation of one request window
  int          ack_lat, last_ack, ack_cnt, en_cnt, busy_cnt;
  logic        fault_v, en_write;
  logic [15:0] rdata_v, en_addr, en_data;
  logic [1:0]  en_size;

  task automatic clear_stats();
    ack_lat = 0; last_ack = 0; ack_cnt = 0; en_cnt = 0; busy_cnt = 0;
    fault_v = 1'b0; rdata_v = 16'h0; en_write = 1'b0; en_size = 2'd0;
    en_addr = 16'h0; en_data = 16'h0;
  endtask

  task automatic sample(input int k);
    if (busy) busy_cnt++;
    if (ram_enable) begin
      en_cnt++; en_write = ram_write; en_size = ram_size;
      en_addr = ram_addr; en_data = ram_data;
    end
    if (ack) begin
      ack_cnt++; last_ack = k;
      if (ack_lat == 0) begin ack_lat = k; fault_v = fault; rdata_v = rdata; end
    end
  endtask

  // called at a negedge; presents the request for the next edge, observes 6 cycles
  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [15:0] a, input logic [15:0] d);
    req = 1'b1; write = w; size = sz; sgn = sg; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0;
    clear_stats();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      sample(k);
    end
    $display("req %s size=%0d signed=%0d addr=%h wdata=%h -> ack@%0d fault=%0d rdata=%h",
             w ? "ST" : "LD", sz, sg, a, d, ack_lat, fault_v, rdata_v);
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_clr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_vec++; if ({ack, fault} !== 2'b00) begin n_bad++; $display("FAIL reset_ack got=%b exp=00", {ack, fault}); end
    n_vec++; if (rdata !== 16'h0) begin n_bad++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
    n_vec++; if ({ram_enable, ram_write, ram_size} !== 4'b0) begin n_bad++; $display("FAIL reset_ramctl got=%b exp=0000", {ram_enable, ram_write, ram_size}); end
    n_vec++; if ({ram_addr, ram_data} !== 32'h0) begin n_bad++; $display("FAIL reset_ramad got=%h exp=0", {ram_addr, ram_data}); end
    reset = 1'b0; mem_clr = 1'b0;
    $display("reset released");
  endtask

  task automatic test_word();
    run_req(1'b1, 2'd2, 1'b0, 16'h0010, 16'hBEEF);
    n_vec++; if (en_cnt !== 1) begin n_bad++; $display("FAIL wst_en_cnt got=%0d exp=1", en_cnt); end
    n_vec++; if ({en_write, en_size} !== 3'b110) begin n_bad++; $display("FAIL wst_ctl got=%b exp=110", {en_write, en_size}); end
    n_vec++; if (en_addr !== 16'h0010 || en_data !== 16'hBEEF) begin n_bad++; $display("FAIL wst_ad got=%h/%h exp=0010/beef", en_addr, en_data); end
    n_vec++; if (ack_lat !== 2 || fault_v !== 1'b0) begin n_bad++; $display("FAIL wst_ack got=%0d/%b exp=2/0", ack_lat, fault_v); end
    n_vec++; if (busy_cnt !== 1 || ack_cnt !== 1) begin n_bad++; $display("FAIL wst_busy got=%0d/%0d exp=1/1", busy_cnt, ack_cnt); end
    run_req(1'b0, 2'd2, 1'b0, 16'h0010, 16'h0000);
    n_vec++; if (rdata_v !== 16'hBEEF) begin n_bad++; $display("FAIL wld_rdata got=%h exp=beef", rdata_v); end
    n_vec++; if (ack_lat !== 3 || fault_v !== 1'b0) begin n_bad++; $display("FAIL wld_ack got=%0d/%b exp=3/0", ack_lat, fault_v); end
    n_vec++; if (busy_cnt !== 2) begin n_bad++; $display("FAIL wld_busy got=%0d exp=2", busy_cnt); end
    n_vec++; if (en_cnt !== 1 || en_write !== 1'b0) begin n_bad++; $display("FAIL wld_en got=%0d/%b exp=1/0", en_cnt, en_write); end
  endtask

  task automatic test_byte();
    run_req(1'b1, 2'd1, 1'b0, 16'h0021, 16'h1280);
    n_vec++; if (en_data !== 16'h0080 || en_size !== 2'd1) begin n_bad++; $display("FAIL bst_data got=%h/%0d exp=0080/1", en_data, en_size); end
    n_vec++; if (rdata !== 16'hBEEF) begin n_bad++; $display("FAIL bst_rdata_hold got=%h exp=beef", rdata); end
    run_req(1'b0, 2'd1, 1'b1, 16'h0021, 16'h0000);
    n_vec++; if (rdata_v !== 16'hFF80 || ack_lat !== 3) begin n_bad++; $display("FAIL bld_signed got=%h@%0d exp=ff80@3", rdata_v, ack_lat); end
    run_req(1'b0, 2'd1, 1'b0, 16'h0021, 16'h0000);
    n_vec++; if (rdata_v !== 16'h0080) begin n_bad++; $display("FAIL bld_unsigned got=%h exp=0080", rdata_v); end
  endtask

  task automatic test_boundary();
    run_req(1'b1, 2'd2, 1'b0, 16'h07FE, 16'h1234);
    n_vec++; if (en_cnt !== 1 || fault_v !== 1'b0 || en_addr !== 16'h07FE) begin n_bad++; $display("FAIL edge_wst got=%0d/%b/%h exp=1/0/07fe", en_cnt, fault_v, en_addr); end
    run_req(1'b0, 2'd1, 1'b1, 16'h07FF, 16'h0000);
    n_vec++; if (rdata_v !== 16'h0012 || fault_v !== 1'b0) begin n_bad++; $display("FAIL edge_bld got=%h/%b exp=0012/0", rdata_v, fault_v); end
  endtask

  task automatic test_faults();
    logic        fw [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  fs [5] = '{2'd0, 2'd3, 2'd1, 2'd2, 2'd2};
    logic [15:0] fa [5] = '{16'h0010, 16'h0010, 16'h0800, 16'h07FF, 16'h0011};
    for (int i = 0; i < 5; i++) begin
      run_req(1'b0, 2'd1, 1'b1, 16'h0021, 16'h0000);
      run_req(fw[i], fs[i], 1'b0, fa[i], 16'h5A5A);
      n_vec++; if (ack_lat !== 1 || fault_v !== 1'b1) begin n_bad++; $display("FAIL fault%0d_ack got=%0d/%b exp=1/1", i, ack_lat, fault_v); end
      n_vec++; if (en_cnt !== 0 || ack_cnt !== 1) begin n_bad++; $display("FAIL fault%0d_en got=%0d/%0d exp=0/1", i, en_cnt, ack_cnt); end
      n_vec++; if (rdata_v !== 16'h0000) begin n_bad++; $display("FAIL fault%0d_rdata got=%h exp=0000", i, rdata_v); end
    end
  endtask

  task automatic test_held_req();
    req = 1'b1; write = 1'b0; size = 2'd2; sgn = 1'b0; addr = 16'h0010; wdata = 16'h0;
    @(posedge clk); #1;
    clear_stats();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      sample(k);
      if (k == 3) req = 1'b0;
    end
    $display("req LD held addr=0010 -> acks=%0d enables=%0d rdata=%h", ack_cnt, en_cnt, rdata_v);
    n_vec++; if (ack_cnt !== 1 || en_cnt !== 1) begin n_bad++; $display("FAIL held_counts got=%0d/%0d exp=1/1", ack_cnt, en_cnt); end
    n_vec++; if (ack_lat !== 3 || rdata_v !== 16'hBEEF) begin n_bad++; $display("FAIL held_rdata got=%0d/%h exp=3/beef", ack_lat, rdata_v); end
  endtask

  task automatic test_back_to_back();
    req = 1'b1; write = 1'b1; size = 2'd2; sgn = 1'b0; addr = 16'h0040; wdata = 16'hA1B2;
    @(posedge clk); #1;
    req = 1'b0;
    clear_stats();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      sample(k);
      if (k == 2) begin
        n_vec++; if (ack !== 1'b1) begin n_bad++; $display("FAIL b2b_first_ack got=%b exp=1", ack); end
        req = 1'b1; write = 1'b0; size = 2'd2; addr = 16'h0040;
        @(posedge clk); #1;
        req = 1'b0;
      end
      if (k == 3) begin
        n_vec++; if ({ram_enable, ram_write} !== 2'b10 || ram_addr !== 16'h0040) begin n_bad++; $display("FAIL b2b_issue got=%b/%h exp=10/0040", {ram_enable, ram_write}, ram_addr); end
      end
    end
    $display("req ST+LD back-to-back addr=0040 -> acks=%0d last_ack@%0d rdata=%h", ack_cnt, last_ack, rdata);
    n_vec++; if (ack_cnt !== 2 || en_cnt !== 2 || last_ack !== 5) begin n_bad++; $display("FAIL b2b_counts got=%0d/%0d/%0d exp=2/2/5", ack_cnt, en_cnt, last_ack); end
    n_vec++; if (rdata !== 16'hA1B2) begin n_bad++; $display("FAIL b2b_rdata got=%h exp=a1b2", rdata); end
  endtask

  task automatic test_reset_in_wait();
    req = 1'b1; write = 1'b0; size = 2'd2; sgn = 1'b0; addr = 16'h0010;
    @(posedge clk); #1;
    req = 1'b0;
    clear_stats();
    @(negedge clk); sample(1);
    @(negedge clk); sample(2);
    reset = 1'b1;
    @(negedge clk); sample(3);
    n_vec++; if ({busy, ack, fault, ram_enable, ram_write} !== 5'b0) begin n_bad++; $display("FAIL rstw_ctl got=%b exp=00000", {busy, ack, fault, ram_enable, ram_write}); end
    n_vec++; if (rdata !== 16'h0 || ram_addr !== 16'h0 || ram_data !== 16'h0 || ram_size !== 2'd0) begin n_bad++; $display("FAIL rstw_data got=%h/%h/%h/%0d exp=0", rdata, ram_addr, ram_data, ram_size); end
    reset = 1'b0;
    $display("reset during WAIT, acks seen=%0d", ack_cnt);
    n_vec++; if (ack_cnt !== 0) begin n_bad++; $display("FAIL rstw_noack got=%0d exp=0", ack_cnt); end
    run_req(1'b0, 2'd2, 1'b0, 16'h0010, 16'h0000);
    n_vec++; if (ack_lat !== 3 || rdata_v !== 16'hBEEF || fault_v !== 1'b0) begin n_bad++; $display("FAIL rstw_reload got=%0d/%h/%b exp=3/beef/0", ack_lat, rdata_v, fault_v); end
  endtask

  initial begin
    req = 1'b0; write = 1'b0; size = 2'd0; sgn = 1'b0; addr = 16'h0; wdata = 16'h0;
    reset = 1'b1; mem_clr = 1'b1;
    test_reset();
    test_word();
    test_byte();
    test_boundary();
    test_faults();
    test_held_req();
    test_back_to_back();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
